// File: rtl/gate_exhaustive_sequencer.sv
// Drives the four {a,b} vectors into a 2-input gate, samples its output after a
// settle interval and compares each sample with a parameterised truth table.
module gate_exhaustive_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH_TABLE   = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       sample_valid,
    output logic [1:0] sample_idx,
    output logic [3:0] mismatch,
    output logic       done,
    output logic       pass
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic [3:0]       mismatch_q, mismatch_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            mismatch_q <= 4'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gate_a_d   = gate_a_q;
        gate_b_d   = gate_b_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = 2'd0;
                    cnt_d      = '0;
                    mismatch_d = 4'd0;
                    pass_d     = 1'b0;
                    gate_a_d   = 1'b0;
                    gate_b_d   = 1'b0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                mismatch_d[idx_q] = (gate_y != TRUTH_TABLE[idx_q]);
                // Last vector goes to DONE so idx never wraps inside a run
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    idx_d                = idx_q + 2'd1;
                    {gate_a_d, gate_b_d} = idx_q + 2'd1;
                    cnt_d                = '0;
                    state_d              = SETTLE;
                end
            end
            DONE: begin
                pass_d   = ~|mismatch_q;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gate_a       = gate_a_q;
    assign gate_b       = gate_b_q;
    assign busy         = (state_q != IDLE);
    assign sample_valid = (state_q == SAMPLE);
    assign sample_idx   = idx_q;
    assign mismatch     = mismatch_q;
    assign done         = (state_q == DONE);
    assign pass         = pass_q;

endmodule

// File: tb/tb_gate_exhaustive_sequencer.sv
// Scoreboard bench: stimulus pushes expected samples/verdicts, a negedge monitor
// pops and compares them whenever the sequencer presents sample_valid or done.
module tb_gate_exhaustive_sequencer;

    typedef struct {
        logic [1:0] idx;
        int         cyc;
    } sample_exp_t;

    typedef struct {
        logic [3:0] mm;
        logic       ps;
        int         cyc;
    } done_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       model_and = 1'b0;

    logic       start0, start1, gate_y0, gate_y1;
    logic       gate_a0, gate_b0, busy0, sample_valid0, done0, pass0;
    logic       gate_a1, gate_b1, busy1, sample_valid1, done1, pass1;
    logic [1:0] sample_idx0, sample_idx1;
    logic [3:0] mismatch0, mismatch1;

    logic       m_gate_a, m_gate_b, m_busy, m_sample_valid, m_done, m_pass;
    logic [1:0] m_sample_idx;
    logic [3:0] m_mismatch;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    sample_exp_t sq[$];
    done_exp_t   dq[$];
    logic        pass_pending = 1'b0;
    logic        pass_expect = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign gate_y0 = model_and ? (gate_a0 & gate_b0) : ~(gate_a0 | gate_b0);
    assign gate_y1 = gate_a1 ^ gate_b1;

    gate_exhaustive_sequencer #(.SETTLE_CYCLES(2), .TRUTH_TABLE(4'b0001)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_y(gate_y0),
        .gate_a(gate_a0), .gate_b(gate_b0), .busy(busy0),
        .sample_valid(sample_valid0), .sample_idx(sample_idx0),
        .mismatch(mismatch0), .done(done0), .pass(pass0)
    );

    gate_exhaustive_sequencer #(.SETTLE_CYCLES(1), .TRUTH_TABLE(4'b0110)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_y(gate_y1),
        .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1),
        .sample_valid(sample_valid1), .sample_idx(sample_idx1),
        .mismatch(mismatch1), .done(done1), .pass(pass1)
    );

    assign m_gate_a       = sel ? gate_a1 : gate_a0;
    assign m_gate_b       = sel ? gate_b1 : gate_b0;
    assign m_busy         = sel ? busy1 : busy0;
    assign m_sample_valid = sel ? sample_valid1 : sample_valid0;
    assign m_sample_idx   = sel ? sample_idx1 : sample_idx0;
    assign m_mismatch     = sel ? mismatch1 : mismatch0;
    assign m_done         = sel ? done1 : done0;
    assign m_pass         = sel ? pass1 : pass0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected sample k lands in cycle (k+1)*(settle+1); done in 4*(settle+1)+1
    task automatic push_run(input int s, input int settle, input logic [3:0] mm,
                            input logic ps, input int nsamp, input bit with_done);
        for (int k = 0; k < nsamp; k++) begin
            sample_exp_t e;
            e.idx = 2'(k);
            e.cyc = s + (k + 1) * (settle + 1) - 1;
            sq.push_back(e);
        end
        if (with_done) begin
            done_exp_t d;
            d.mm  = mm;
            d.ps  = ps;
            d.cyc = s + 4 * (settle + 1);
            dq.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        if (pass_pending) begin
            check_output("pass_after_done", 32'(m_pass), 32'(pass_expect));
            pass_pending = 1'b0;
        end
        if (m_sample_valid) begin
            if (sq.size() == 0) begin
                check_output("unexpected_sample", 32'(1), 32'(0));
            end else begin
                sample_exp_t e;
                e = sq.pop_front();
                check_output("sample_idx", 32'(m_sample_idx), 32'(e.idx));
                check_output("sample_vector", 32'({m_gate_a, m_gate_b}), 32'(e.idx));
                check_output("sample_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (m_done) begin
            if (dq.size() == 0) begin
                check_output("unexpected_done", 32'(1), 32'(0));
            end else begin
                done_exp_t d;
                d = dq.pop_front();
                check_output("done_mismatch", 32'(m_mismatch), 32'(d.mm));
                check_output("done_cycle", 32'(cyc), 32'(d.cyc));
                pass_expect  = d.ps;
                pass_pending = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sq.size() != 0 || dq.size() != 0 || pass_pending) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("drain_timeout", 32'(1), 32'(0));
    endtask

    task automatic apply_stimulus(input logic use_sel, input logic use_and, input int settle,
                                  input logic [3:0] mm, input logic ps);
        int s;
        sel       = use_sel;
        model_and = use_and;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_run(s, settle, mm, ps, 4, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", 32'(m_busy), 32'(1));
        wait_idle();
    endtask

    initial begin
        int s;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        check_output("rst_gate_ab", 32'({gate_a0, gate_b0}), 32'(0));
        check_output("rst_busy", 32'(busy0), 32'(0));
        check_output("rst_sample_valid", 32'(sample_valid0), 32'(0));
        check_output("rst_sample_idx", 32'(sample_idx0), 32'(0));
        check_output("rst_mismatch", 32'(mismatch0), 32'(0));
        check_output("rst_done", 32'(done0), 32'(0));
        check_output("rst_pass", 32'(pass0), 32'(0));
        check_output("rst_busy1", 32'(busy1), 32'(0));
        rst = 1'b0;

        $display("[TB] NOR gate against NOR table");
        apply_stimulus(1'b0, 1'b0, 2, 4'b0000, 1'b1);

        $display("[TB] AND gate against NOR table");
        apply_stimulus(1'b0, 1'b1, 2, 4'b1001, 1'b0);

        $display("[TB] start held high, back-to-back runs");
        sel       = 1'b0;
        model_and = 1'b0;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_run(s, 2, 4'b0000, 1'b1, 4, 1'b1);
        push_run(s + 14, 2, 4'b0000, 1'b1, 4, 1'b1);
        push_run(s + 28, 2, 4'b0000, 1'b1, 4, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cyc == s + 12) check_output("b2b_busy_in_done", 32'(m_busy), 32'(1));
            if (cyc == s + 13) check_output("b2b_busy_idle", 32'(m_busy), 32'(0));
            if (cyc == s + 14) check_output("b2b_busy_run2", 32'(m_busy), 32'(1));
        end
        start = 1'b0;
        wait_idle();

        $display("[TB] reset during vector 2 settle");
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        push_run(s, 2, 4'b0000, 1'b0, 2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 6) @(negedge clk);
        check_output("abort_vector2", 32'({gate_a0, gate_b0}), 32'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_busy", 32'(busy0), 32'(0));
        check_output("abort_gate_ab", 32'({gate_a0, gate_b0}), 32'(0));
        check_output("abort_mismatch", 32'(mismatch0), 32'(0));
        check_output("abort_pass", 32'(pass0), 32'(0));
        check_output("abort_done", 32'(done0), 32'(0));
        check_output("abort_queue_empty", 32'(sq.size()), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 2, 4'b0000, 1'b1);

        $display("[TB] XOR gate, SETTLE_CYCLES=1");
        apply_stimulus(1'b1, 1'b0, 1, 4'b0000, 1'b1);

        for (int i = 0; i < 4; i++) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
